// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top - FPGA2i-MAX chargen demo
//
// A character generator (RFC 864 style rotating printable lines) feeds a
// small synchronous FIFO.  An 8N1 UART transmitter drains the FIFO.  A
// free-running counter blinks a heartbeat LED, and two more LEDs show status.
// Everything runs on the rising edge of clk.
//
// Ports:
//   clk      in   system clock
//   n_rst    in   asynchronous active-low reset
//   dip      in   [2:0] DIP switches, reserved, ignored
//   uart_rx  in   UART receive, reserved, ignored
//   uart_tx  out  UART transmit, 8N1, LSB first, idles high
//   led      out  [2:0] led[0] heartbeat, led[1] FIFO full, led[2] TX busy
// -----------------------------------------------------------------------------
module top #(
  parameter int FIFO_DEPTH     = 16,
  parameter int UART_CDIV      = 434,
  parameter int BLINK_INTERVAL = 25000000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] dip,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [2:0] led
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(UART_CDIV);
  localparam int BW = $clog2(BLINK_INTERVAL + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] CDIV_LAST  = DW'(UART_CDIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_INTERVAL - 1);

  // Reserved inputs are folded into a sink that drives nothing.
  logic unused_inputs;
  assign unused_inputs = ^{dip, uart_rx};

  function automatic logic [7:0] next_printable(input logic [7:0] c);
    return (c == 8'h7E) ? 8'h20 : c + 8'h01;
  endfunction

  // ---------------------------------------------------------------------------
  // Character generator
  // ---------------------------------------------------------------------------
  logic [7:0] gen_ch_q;       // next printable character of the current line
  logic [7:0] gen_line_ch_q;  // first character of the current line
  logic [6:0] gen_col_q;      // 0..71 printable, 72 CR, 73 LF
  logic [7:0] gen_byte;

  logic            fifo_wr;
  logic            fifo_rd;
  logic [CW-1:0]   fifo_count_q;
  logic [CW-1:0]   fifo_count_d;
  logic [AW-1:0]   fifo_wr_ptr_q;
  logic [AW-1:0]   fifo_rd_ptr_q;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [7:0]      fifo_rd_data;
  logic            fifo_empty;
  logic            fifo_full;

  always_comb begin
    gen_byte = gen_ch_q;
    if (gen_col_q == 7'd72)      gen_byte = 8'h0D;
    else if (gen_col_q == 7'd73) gen_byte = 8'h0A;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gen_ch_q      <= 8'h20;
      gen_line_ch_q <= 8'h20;
      gen_col_q     <= 7'd0;
    end else if (fifo_wr) begin
      if (gen_col_q == 7'd73) begin
        gen_col_q     <= 7'd0;
        gen_line_ch_q <= next_printable(gen_line_ch_q);
        gen_ch_q      <= next_printable(gen_line_ch_q);
      end else begin
        gen_col_q <= gen_col_q + 7'd1;
        // The character register is left alone across CR/LF; it is
        // reloaded from the line start when the line ends.
        if (gen_col_q < 7'd71) gen_ch_q <= next_printable(gen_ch_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign fifo_empty   = (fifo_count_q == '0);
  assign fifo_full    = (fifo_count_q == DEPTH_C);
  assign fifo_rd_data = fifo_mem[fifo_rd_ptr_q];

  // A pop in the same clock frees the slot the generator writes into, so a
  // full FIFO stays full in steady state instead of dipping for one clock
  // per frame; a write into a full FIFO with no pop is dropped.
  assign fifo_wr = !fifo_full || fifo_rd;

  always_comb begin
    fifo_count_d = fifo_count_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fifo_wr_ptr_q <= '0;
      fifo_rd_ptr_q <= '0;
      fifo_count_q  <= '0;
    end else begin
      if (fifo_wr) fifo_wr_ptr_q <= fifo_wr_ptr_q + AW'(1);
      if (fifo_rd) fifo_rd_ptr_q <= fifo_rd_ptr_q + AW'(1);
      fifo_count_q <= fifo_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[fifo_wr_ptr_q] <= gen_byte;
  end

  // ---------------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  tx_state_t     tx_state_q;
  tx_state_t     tx_state_d;
  logic [DW-1:0] tx_cdiv_q;
  logic [2:0]    tx_bit_idx_q;
  logic [7:0]    tx_byte_q;
  logic          tx_bit_end;
  logic          tx_pop;
  logic          tx_line;
  logic          uart_tx_q;

  assign tx_bit_end = (tx_cdiv_q == CDIV_LAST);
  assign fifo_rd    = tx_pop;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_byte_q[tx_bit_idx_q];
        if (tx_bit_end && (tx_bit_idx_q == 3'd7)) tx_state_d = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          // Popping here keeps frames back to back with no idle clock.
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state_q   <= TX_IDLE;
      tx_cdiv_q    <= '0;
      tx_bit_idx_q <= 3'd0;
      uart_tx_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      if ((tx_state_q == TX_IDLE) || tx_bit_end) tx_cdiv_q <= '0;
      else                                       tx_cdiv_q <= tx_cdiv_q + DW'(1);
      if ((tx_state_q == TX_DATA) && tx_bit_end) tx_bit_idx_q <= tx_bit_idx_q + 3'd1;
      // The line register trails the state by one clock, so every bit,
      // the start bit included, is held for exactly UART_CDIV clocks.
      uart_tx_q <= tx_line;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop) tx_byte_q <= fifo_rd_data;
  end

  // ---------------------------------------------------------------------------
  // Heartbeat and status LEDs
  // ---------------------------------------------------------------------------
  logic [BW-1:0] blink_cnt_q;
  logic [2:0]    led_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      blink_cnt_q <= '0;
      led_q       <= 3'b000;
    end else begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        led_q[0]    <= ~led_q[0];
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
      // Full flag follows the occupancy this edge produces.
      led_q[1] <= (fifo_count_d == DEPTH_C);
      led_q[2] <= (tx_state_q != TX_IDLE);
    end
  end

  assign uart_tx = uart_tx_q;
  assign led     = led_q;

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top - self-checking bench for the chargen demo top.
//
// Two instances share clock, reset and the reserved inputs:
//   u_a : FIFO_DEPTH=4, UART_CDIV=4, BLINK_INTERVAL=4
//   u_b : FIFO_DEPTH=2, UART_CDIV=2, BLINK_INTERVAL=7 (runs far enough into
//         the stream to cover line rollover and the 0x7E -> 0x20 wrap)
// Expected outputs come from a clock-indexed model of the serial line:
// frames are back to back from clock 3 after release, frame f carries
// stream byte f, and stream byte k is derived from its line and column.
// -----------------------------------------------------------------------------
module tb_top;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] dip;
  logic       uart_rx;
  logic       tx_a, tx_b;
  logic [2:0] led_a, led_b;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;  // rising edges since the last reset release

  always #50 clk = ~clk;

  top #(.FIFO_DEPTH(4), .UART_CDIV(4), .BLINK_INTERVAL(4)) u_a (
    .clk(clk), .n_rst(n_rst), .dip(dip), .uart_rx(uart_rx),
    .uart_tx(tx_a), .led(led_a)
  );

  top #(.FIFO_DEPTH(2), .UART_CDIV(2), .BLINK_INTERVAL(7)) u_b (
    .clk(clk), .n_rst(n_rst), .dip(dip), .uart_rx(uart_rx),
    .uart_tx(tx_b), .led(led_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at clock %0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // Byte k of the generated stream.
  function automatic logic [7:0] stream_byte(input int k);
    int line;
    int col;
    line = k / 74;
    col  = k % 74;
    if (col == 72) return 8'h0D;
    if (col == 73) return 8'h0A;
    return 8'(32 + ((line % 95) + col) % 95);
  endfunction

  // Serial line level after rising edge tt, bit period cdiv clocks.
  function automatic logic exp_tx(input int tt, input int cdiv);
    int u;
    int f;
    int b;
    logic [7:0] by;
    if (tt < 3) return 1'b1;
    u  = tt - 3;
    f  = u / (10 * cdiv);
    b  = (u % (10 * cdiv)) / cdiv;
    by = stream_byte(f);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  function automatic logic [2:0] exp_led(input int tt, input int depth, input int bi);
    logic [2:0] r;
    r[2] = (tt >= 3);
    r[1] = (tt >= depth + 1);
    r[0] = (((tt / bi) % 2) == 1);
    return r;
  endfunction

  task automatic check_all();
    check("tx_a",  32'(tx_a),  32'(exp_tx(t, 4)));
    check("led_a", 32'(led_a), 32'(exp_led(t, 4, 4)));
    check("tx_b",  32'(tx_b),  32'(exp_tx(t, 2)));
    check("led_b", 32'(led_b), 32'(exp_led(t, 2, 7)));
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_tx_a"},  32'(tx_a),  32'(1));
    check({phase, "_led_a"}, 32'(led_a), 32'(0));
    check({phase, "_tx_b"},  32'(tx_b),  32'(1));
    check({phase, "_led_b"}, 32'(led_b), 32'(0));
  endtask

  // Advance n clocks, sampling on the falling edge. The reserved inputs
  // stay X for the first 30 clocks after a release, then turn random.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      if (t > 30) begin
        dip     = 3'($urandom);
        uart_rx = 1'($urandom);
      end
      check_all();
    end
  endtask

  initial begin
    int fcur;
    int pos;

    n_rst   = 1'b1;
    dip     = 3'bxxx;
    uart_rx = 1'bx;

    // Power-on reset pulse, 100 ns low.
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    n_rst = 1'b1;
    t = 0;
    #1;
    check_all();

    // Long run: first frame, back-to-back stream, line structure, LEDs.
    run_cycles(40000);

    // Reset during data bit 7 of a randomly chosen upcoming frame of u_a.
    // Bit 7 of a character is always 0, so the line is low right before.
    fcur = (t - 3) / 40 + 1 + int'($urandom_range(0, 5));
    pos  = 3 + 40 * fcur + 32 + int'($urandom_range(0, 2));
    run_cycles(pos - t);
    @(posedge clk);
    #20;
    check("pre_rst_tx_a", 32'(tx_a), 32'(exp_tx(t + 1, 4)));
    n_rst = 1'b0;
    dip     = 3'bxxx;
    uart_rx = 1'bx;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    check_reset_outputs("hold");
    @(negedge clk);
    n_rst = 1'b1;
    t = 0;
    #1;
    check_all();

    // Stream restarts from line 0.
    run_cycles(2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
